rvx_tmr_fault_manager: RTL
==========================

RVX_TMR_FAULT_MANAGER -- requirements
Module: rvx_tmr_fault_manager

Interface
REQ-001 SHALL have parameter BW_DATA, default 32: width of one replica word.
REQ-002 SHALL have parameter THRESHOLD, default 4: consecutive single-lane mismatches that declare a lane faulty; legal range 1..255.
REQ-003 SHALL have parameter BW_CNT, default 8: width of each per-lane error counter.
REQ-004 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rstnn, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port lane_data, input, 3*BW_DATA: replica words; lane i occupies bits [BW_DATA*(i+1)-1 -: BW_DATA].
REQ-007 SHALL have port lane_valid, input, 1: all three lanes carry a beat this cycle.
REQ-008 SHALL have port clear, input, 1: single-cycle request to return to NORMAL after software resync.
REQ-009 SHALL have port voted_data, output, BW_DATA: corrected word.
REQ-010 SHALL have port voted_valid, output, 1: voted_data carries a beat.
REQ-011 SHALL have port state, output, 2: 0=NORMAL, 1=SUSPECT, 2=DEGRADED, 3=FAILED.
REQ-012 SHALL have port fault_lane, output, 2: 0=none; 1..3=lane 0..2 excluded.
REQ-013 SHALL have port fault_irq, output, 1: one-cycle pulse on each entry into DEGRADED or FAILED.
REQ-014 SHALL have port err_count, output, 3*BW_CNT: per-lane counters; present only under REQ-030.

Function
REQ-015 SHALL register outputs with one-cycle latency: voted_valid(t+1)=lane_valid(t) in all states except FAILED, where voted_valid is held 0.
REQ-016 SHALL flag lane i as mismatching on a valid beat when any bit of lane i differs from the bitwise 2-of-3 majority.
REQ-017 SHALL drive voted_data from the bitwise majority in NORMAL and SUSPECT, and from the lowest-indexed non-excluded lane in DEGRADED and FAILED.
REQ-018 NORMAL: one lane mismatches -> SUSPECT, suspect lane latched, count=1; THRESHOLD=1 -> DEGRADED directly; two or three lanes mismatch -> FAILED.
REQ-019 SUSPECT: same lane mismatches -> count+1, and on reaching THRESHOLD -> DEGRADED with fault_lane set; clean beat -> NORMAL, count=0; a different single lane mismatches -> stay SUSPECT, suspect lane replaced, count=1; multi-lane mismatch -> FAILED.
REQ-020 SUSPECT SHALL hold its count across cycles with lane_valid=0.
REQ-021 DEGRADED: the two remaining lanes are compared directly; any difference -> FAILED; the excluded lane is ignored.
REQ-022 FAILED SHALL be sticky until clear or reset.
REQ-023 clear SHALL force next state NORMAL, count 0, fault_lane 0; a valid beat in the same cycle is still voted and output but not evaluated.
REQ-024 Invalid beats (lane_valid=0) SHALL cause no state transition and no counter change.
REQ-025 fault_irq SHALL pulse once per entry; NORMAL->FAILED and DEGRADED->FAILED each give exactly one pulse.

Reset
REQ-026 On rstnn=0 at a clock edge: state=NORMAL, fault_lane=0, suspect count=0, voted_valid=0, voted_data=0, fault_irq=0, err_count=0.
REQ-027 Reset mid-operation SHALL discard any in-flight beat and SHALL NOT pulse fault_irq.

Configuration
REQ-028 Macro RVX_TMR_FAULT_MANAGER_ERRCNT_EN SHALL control per-lane error counters.
REQ-029 Without the macro: err_count port and counters are absent; all other behaviour is identical.
REQ-030 With the macro: counter i increments on every evaluated beat where lane i mismatches (any state but FAILED), saturates at all-ones, and is cleared by reset and clear.

Structure
REQ-031 State encodings, fault_lane codes and lane count (3) SHALL live in a shared package/include, rvx_tmr_pkg.
REQ-032 A sub-module rvx_tmr_vote3 SHALL compute the majority word and the three per-lane mismatch flags combinationally; the FSM, counters and output registers reside in the top.

Verification (BW_DATA=8, THRESHOLD=4)
REQ-033 Three lanes 0x5A, valid -> next cycle voted_data=0x5A, voted_valid=1, state=0, no irq.
REQ-034 Lane 1 =0x5B, others 0x5A, for 4 valid beats -> state 1,1,1 then 2; fault_lane=2; one irq pulse; voted_data=0x5A throughout.
REQ-035 Lane 2 mismatches 3 beats, then 1 clean beat -> state returns to 0; count restarts at 1 on the next mismatch.
REQ-036 Lanes 0x01/0x02/0x04 (all differ) -> FAILED next cycle, irq pulse, voted_valid=0 until clear; clear -> state 0.
REQ-037 In DEGRADED with lane 1 excluded, lane0=0x10, lane2=0x11 -> FAILED with one irq pulse; with ERRCNT_EN, lane 1 counter saturates at 0xFF after 300 mismatches.

Source files
------------

// File: rtl/rvx_tmr_pkg.sv
// rvx_tmr_pkg: shared lane count, state encodings and fault_lane codes for the TMR fault manager
package rvx_tmr_pkg;
  localparam int NUM_LANES = 3;
  localparam logic [1:0] ST_NORMAL   = 2'd0;
  localparam logic [1:0] ST_SUSPECT  = 2'd1;
  localparam logic [1:0] ST_DEGRADED = 2'd2;
  localparam logic [1:0] ST_FAILED   = 2'd3;
  localparam logic [1:0] FL_NONE  = 2'd0;
  localparam logic [1:0] FL_LANE0 = 2'd1;
  localparam logic [1:0] FL_LANE1 = 2'd2;
  localparam logic [1:0] FL_LANE2 = 2'd3;
  function automatic logic [1:0] lane_code(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction
endpackage

// File: rtl/rvx_tmr_vote3.sv
// rvx_tmr_vote3: bitwise 2-of-3 majority word and per-lane mismatch flags
module rvx_tmr_vote3 import rvx_tmr_pkg::*; #(
  parameter int BW_DATA = 32
) (
  input  logic [NUM_LANES*BW_DATA-1:0] lane_data,
  output logic [BW_DATA-1:0]           majority,
  output logic [NUM_LANES-1:0]         mismatch
);
  logic [BW_DATA-1:0] a, b, c;
  assign a = lane_data[BW_DATA-1:0];
  assign b = lane_data[2*BW_DATA-1 -: BW_DATA];
  assign c = lane_data[3*BW_DATA-1 -: BW_DATA];
  assign majority = (a & b) | (a & c) | (b & c);
  assign mismatch = {|(c ^ majority), |(b ^ majority), |(a ^ majority)};
endmodule

// File: rtl/rvx_tmr_fault_manager.sv
// rvx_tmr_fault_manager: TMR voter with lane-fault FSM; RVX_TMR_FAULT_MANAGER_ERRCNT_EN adds per-lane error counters
module rvx_tmr_fault_manager import rvx_tmr_pkg::*; #(
  parameter int BW_DATA   = 32,
  parameter int THRESHOLD = 4,
  parameter int BW_CNT    = 8
) (
  input  logic                         clk,
  input  logic                         rstnn,
  input  logic [NUM_LANES*BW_DATA-1:0] lane_data,
  input  logic                         lane_valid,
  input  logic                         clear,
  output logic [BW_DATA-1:0]           voted_data,
  output logic                         voted_valid,
  output logic [1:0]                   state,
  output logic [1:0]                   fault_lane,
  output logic                         fault_irq
`ifdef RVX_TMR_FAULT_MANAGER_ERRCNT_EN
  ,
  output logic [NUM_LANES*BW_CNT-1:0]  err_count
`endif
);
  localparam int CW = (BW_CNT > 8) ? BW_CNT : 8;
  localparam logic [CW-1:0] THR = CW'(THRESHOLD);
  logic [BW_DATA-1:0] a, b, c, maj, sel;
  logic [NUM_LANES-1:0] mm;
  logic [1:0] st_nx, fl_nx, sl, sl_nx, sidx;
  logic [CW-1:0] cnt, cnt_nx, nc;
  logic multi, single, pair_diff;
  rvx_tmr_vote3 #(.BW_DATA(BW_DATA)) u_vote (
    .lane_data(lane_data),
    .majority (maj),
    .mismatch (mm)
  );
  assign a = lane_data[BW_DATA-1:0];
  assign b = lane_data[2*BW_DATA-1 -: BW_DATA];
  assign c = lane_data[3*BW_DATA-1 -: BW_DATA];
  assign multi = (mm[0] & mm[1]) | (mm[0] & mm[2]) | (mm[1] & mm[2]);
  assign single = |mm & ~multi;
  assign sidx = mm[0] ? 2'd0 : mm[1] ? 2'd1 : 2'd2;
  assign nc = (state == ST_SUSPECT && sidx == sl) ? cnt + CW'(1) : CW'(1);
  assign pair_diff = (fault_lane == FL_LANE0) ? (b != c) : (fault_lane == FL_LANE1) ? (a != c) : (a != b);
  assign sel = state[1] ? ((fault_lane == FL_LANE0) ? b : a) : maj;
  // next-state evaluation of one beat; clear overrides, invalid beats change nothing
  always_comb begin
    st_nx = state;
    fl_nx = fault_lane;
    sl_nx = sl;
    cnt_nx = cnt;
    if (clear) begin
      st_nx = ST_NORMAL;
      fl_nx = FL_NONE;
      cnt_nx = '0;
    end else if (lane_valid && !state[1]) begin
      if (multi) st_nx = ST_FAILED;
      else if (single) begin
        st_nx = (nc >= THR) ? ST_DEGRADED : ST_SUSPECT;
        fl_nx = (nc >= THR) ? lane_code(sidx) : fault_lane;
        cnt_nx = (nc >= THR) ? '0 : nc;
        sl_nx = sidx;
      end else begin
        st_nx = ST_NORMAL;
        cnt_nx = '0;
      end
    end else if (lane_valid && state == ST_DEGRADED && pair_diff) st_nx = ST_FAILED;
  end
  // state and registered outputs; irq fires on every entry into DEGRADED or FAILED
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      state <= ST_NORMAL;
      fault_lane <= FL_NONE;
      sl <= '0;
      cnt <= '0;
      voted_valid <= 1'b0;
      voted_data <= '0;
      fault_irq <= 1'b0;
    end else begin
      state <= st_nx;
      fault_lane <= fl_nx;
      sl <= sl_nx;
      cnt <= cnt_nx;
      voted_valid <= lane_valid & (state != ST_FAILED | clear);
      voted_data <= lane_valid ? sel : voted_data;
      fault_irq <= st_nx[1] & (st_nx != state);
    end
  end
`ifdef RVX_TMR_FAULT_MANAGER_ERRCNT_EN
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_ec
    logic [BW_CNT-1:0] ec;
    // saturating count of evaluated beats where this lane disagrees with the majority
    always_ff @(posedge clk) begin
      if (!rstnn || clear) ec <= '0;
      else if (lane_valid && state != ST_FAILED && mm[i] && !(&ec)) ec <= ec + BW_CNT'(1);
    end
    assign err_count[BW_CNT*(i+1)-1 -: BW_CNT] = ec;
  end
`endif
endmodule
